jpeg_idct_1d_pipe: RTL and testbench

//  Streaming, pipelined 8-point 1-D IDCT with a valid/ready handshake on both sides.

---
 rtl/jpeg_idct_1d_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_jpeg_idct_1d_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_idct_1d_pipe.sv
// Streaming 8-point 1-D IDCT with a three-register pipeline and valid/ready
// handshakes. Optional per-vector pixel mode adds the +128 level shift and
// clamps to 0..255, so one block serves both the row and column passes.
module jpeg_idct_1d_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int COEF_FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*IN_W-1:0]    in_data,
  input  logic                 in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data
);

  localparam int SHIFT  = COEF_FRAC + 1;
  localparam int W_W    = COEF_FRAC + 2;
  localparam int PROD_W = IN_W + W_W;
  localparam int ACC_W  = IN_W + COEF_FRAC + 5;
  localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint OUT_MIN = -OUT_MAX - 1;

  // cos(k*pi/16) scaled by 2^COEF_FRAC and rounded. Evaluated with an
  // integer Taylor series in Q28 so elaboration needs no real arithmetic.
  function automatic longint cos_coef(input int k);
    longint theta;
    longint term;
    longint sum;
    theta = (longint'(843314857) * longint'(k)) / 16;
    term  = longint'(1) <<< 28;
    sum   = term;
    for (int n = 1; n <= 12; n++) begin
      term = (term * theta) >>> 28;
      term = (term * theta) >>> 28;
      term = -term / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return (sum * (longint'(1) <<< COEF_FRAC) + (longint'(1) <<< 27)) >>> 28;
  endfunction

  // IDCT matrix entry for coefficient u feeding output sample x. The angle
  // index (2x+1)*u is reduced mod 32 and folded into the first quadrant,
  // with the sign following the cosine quadrant.
  function automatic int idct_weight(input int u, input int x);
    int m;
    if (u == 0) begin
      return int'(cos_coef(4));
    end
    m = ((2 * x + 1) * u) % 32;
    if (m <= 8) begin
      return int'(cos_coef(m));
    end else if (m <= 16) begin
      return -int'(cos_coef(16 - m));
    end else if (m <= 24) begin
      return -int'(cos_coef(m - 16));
    end
    return int'(cos_coef(32 - m));
  endfunction

  // Flattened weight table, entry (x*8+u).
  function automatic logic [64*W_W-1:0] build_wgt_tbl();
    logic [64*W_W-1:0] t;
    t = '0;
    for (int x = 0; x < 8; x++) begin
      for (int u = 0; u < 8; u++) begin
        t[(x * 8 + u) * W_W +: W_W] = W_W'(idct_weight(u, x));
      end
    end
    return t;
  endfunction

  localparam logic [64*W_W-1:0] WGT_TBL = build_wgt_tbl();

  function automatic logic signed [PROD_W-1:0] mul_w(
    input logic signed [IN_W-1:0] a,
    input logic signed [W_W-1:0]  w
  );
    logic signed [PROD_W-1:0] ae;
    logic signed [PROD_W-1:0] we;
    ae = PROD_W'(a);
    we = PROD_W'(w);
    return ae * we;
  endfunction

  // Round half up then arithmetic shift (floor after the bias).
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] bias;
    bias = ACC_W'(1) <<< (SHIFT - 1);
    return (a + bias) >>> SHIFT;
  endfunction

  // Saturate to the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_out(
    input logic signed [ACC_W-1:0] r
  );
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'(OUT_MAX);
    lo = ACC_W'(OUT_MIN);
    if (r > hi) begin
      return OUT_W'(hi);
    end else if (r < lo) begin
      return OUT_W'(lo);
    end
    return OUT_W'(r);
  endfunction

  // Level shift by +128 and clamp to an 8-bit pixel, zero-extended.
  function automatic logic signed [OUT_W-1:0] clamp_pix(
    input logic signed [ACC_W-1:0] r
  );
    logic signed [ACC_W-1:0] p;
    p = r + ACC_W'(128);
    if (p < 0) begin
      return '0;
    end else if (p > 255) begin
      return OUT_W'(255);
    end
    return OUT_W'(p);
  endfunction

  logic                     advance;
  logic                     vld_p0;
  logic                     vld_p1;
  logic                     vld_p2;
  logic                     pix_p0;
  logic                     pix_p1;
  logic signed [IN_W-1:0]   lane    [8];
  logic signed [PROD_W-1:0] prod_p0 [8][8];
  logic signed [ACC_W-1:0]  acc     [8];
  logic signed [ACC_W-1:0]  rnd_p1  [8];
  logic signed [OUT_W-1:0]  out_p2  [8];

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2;

  // Unpack the input coefficient lanes.
  always_comb begin
    for (int u = 0; u < 8; u++) begin
      lane[u] = in_data[u*IN_W +: IN_W];
    end
  end

  // Valid bits shift with the data; reset empties the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage p0: register all 64 lane*weight products ----
  always_ff @(posedge clk) begin
    if (advance) begin
      pix_p0 <= in_pixel;
      for (int x = 0; x < 8; x++) begin
        for (int u = 0; u < 8; u++) begin
          prod_p0[x][u] <= mul_w(lane[u], $signed(WGT_TBL[(x*8+u)*W_W +: W_W]));
        end
      end
    end
  end

  // Sum the eight products of each output lane.
  always_comb begin
    for (int x = 0; x < 8; x++) begin
      acc[x] = '0;
      for (int u = 0; u < 8; u++) begin
        acc[x] = acc[x] + ACC_W'(prod_p0[x][u]);
      end
    end
  end

  // ---- stage p1: register the rounded sums ----
  always_ff @(posedge clk) begin
    if (advance) begin
      pix_p1 <= pix_p0;
      for (int x = 0; x < 8; x++) begin
        rnd_p1[x] <= round_shift(acc[x]);
      end
    end
  end

  // ---- stage p2: register saturated or pixel-clamped outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < 8; x++) begin
        out_p2[x] <= '0;
      end
    end else if (advance) begin
      for (int x = 0; x < 8; x++) begin
        out_p2[x] <= pix_p1 ? clamp_pix(rnd_p1[x]) : sat_out(rnd_p1[x]);
      end
    end
  end

  // Pack the output lanes.
  always_comb begin
    out_data = '0;
    for (int x = 0; x < 8; x++) begin
      out_data[x*OUT_W +: OUT_W] = out_p2[x];
    end
  end

endmodule

// File: tb/tb_jpeg_idct_1d_pipe.sv
// Testbench for jpeg_idct_1d_pipe: directed vector table, reset-in-flight
// sequence, backpressure stream and a random sweep against a reference model.
module tb_jpeg_idct_1d_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_pixel;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jpeg_idct_1d_pipe #(.IN_W(16), .OUT_W(16), .COEF_FRAC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct packed {
    logic [127:0] f;
    logic         pix;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [127:0] rep(input int v);
    return {8{16'(v)}};
  endfunction

  function automatic logic [127:0] lane0(input int v);
    return {112'd0, 16'(v)};
  endfunction

  function automatic logic [127:0] rnd_vec();
    logic [127:0] v;
    for (int u = 0; u < 8; u++) begin
      v[u*16 +: 16] = 16'(int'($urandom_range(4094)) - 2047);
    end
    return v;
  endfunction

  // Reference: integer weight table C0..C8 for Q8, standard IDCT matrix.
  function automatic logic [127:0] model(input logic [127:0] f, input logic pix);
    int cw [9];
    logic [127:0] res;
    longint acc;
    longint r;
    int m;
    int w;
    logic signed [15:0] fu;
    cw = '{256, 251, 237, 213, 181, 142, 98, 50, 0};
    res = '0;
    for (int x = 0; x < 8; x++) begin
      acc = 0;
      for (int u = 0; u < 8; u++) begin
        fu = f[u*16 +: 16];
        if (u == 0) begin
          w = 181;
        end else begin
          m = ((2 * x + 1) * u) % 32;
          if (m <= 8)       w = cw[m];
          else if (m <= 16) w = -cw[16 - m];
          else if (m <= 24) w = -cw[m - 16];
          else              w = cw[32 - m];
        end
        acc += longint'(fu) * w;
      end
      r = (acc + 256) >>> 9;
      if (pix) begin
        r = r + 128;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
      end else begin
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
      end
      res[x*16 +: 16] = 16'(r);
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream n random vectors through the scoreboard; bp randomises
  // out_ready and inserts input bubbles.
  task automatic run_stream(input string name, input int n, input bit bp);
    logic [127:0] expq [$];
    logic [127:0] cur_f;
    logic [127:0] held;
    logic [127:0] e;
    logic         cur_p;
    bit           pend;
    bit           hold;
    int           sent;
    int           recv;
    int           cyc;
    pend = 0; hold = 0; sent = 0; recv = 0; cyc = 0;
    cur_f = '0; cur_p = 0; held = '0;
    while (recv < n && cyc < 20 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk({name, "_stall_valid"}, {127'd0, out_valid}, 128'd1);
        chk({name, "_stall_data"}, out_data, held);
      end
      if (!pend && sent < n && (!bp || $urandom_range(3) != 0)) begin
        cur_f = rnd_vec();
        cur_p = 1'($urandom_range(1));
        pend  = 1;
      end
      in_valid  = pend;
      in_data   = cur_f;
      in_pixel  = cur_p;
      out_ready = bp ? ($urandom_range(1) == 1) : 1'b1;
      #1;
      hold = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        expq.push_back(model(cur_f, cur_p));
        sent++;
        pend = 0;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra: got output %h with nothing expected", name, out_data);
        end else begin
          e = expq.pop_front();
          chk({name, "_data"}, out_data, e);
        end
        recv++;
      end
    end
    if (recv < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d outputs expected %0d", name, recv, n);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    tbl[0] = '{f: lane0(64),    pix: 1'b0, exp: rep(23)};
    tbl[1] = '{f: lane0(64),    pix: 1'b1, exp: rep(151)};
    tbl[2] = '{f: lane0(4000),  pix: 1'b0, exp: rep(1414)};
    tbl[3] = '{f: lane0(4000),  pix: 1'b1, exp: rep(255)};
    tbl[4] = '{f: lane0(-4000), pix: 1'b0, exp: rep(-1414)};
    tbl[5] = '{f: lane0(-4000), pix: 1'b1, exp: rep(0)};
    tbl[6] = '{f: {96'd0, 16'sd512, 16'd0}, pix: 1'b0,
               exp: {-16'sd251, -16'sd213, -16'sd142, -16'sd50,
                     16'sd50, 16'sd142, 16'sd213, 16'sd251}};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_pixel = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = tbl[i].f; in_pixel = tbl[i].pix;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_early", i), {127'd0, out_valid}, 128'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {127'd0, out_valid}, 128'd1);
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].exp);
    end

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rnd_vec(); in_pixel = 1'($urandom_range(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_out_data", out_data, 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_flush%0d", i), {127'd0, out_valid}, 128'd0);
    end
    in_valid = 1'b1; in_data = lane0(64); in_pixel = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_rst_early", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    chk("after_rst_valid", {127'd0, out_valid}, 128'd1);
    chk("after_rst_data", out_data, rep(151));
    @(negedge clk);

    run_stream("bp", 20, 1'b1);
    run_stream("sweep", 1000, 1'b0);
    run_stream("bp_mix", 60, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
